// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit that owns HI/LO.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, b});
    // When the trial subtract fits, the true difference is below b, so W bits suffice.
    rem_sub = shifted[WIDTH-1:0] - b;
    if (is_div) begin
      hi_nxt = fits ? rem_sub : shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], fits};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle mult/multu/div/divu unit with architectural HI/LO and mthi/mtlo access.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               signed_op;
  logic               op_is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opb_mag, opa_orig;
  logic [WIDTH-1:0]   step_hi, step_lo;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    cond_neg = neg ? (~x + 1'b1) : x;
  endfunction

  assign accept    = (state == ST_IDLE) && start;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  // Magnitude of the most-negative value wraps to itself, which is correct as unsigned.
  assign a_mag     = cond_neg(opa, signed_op & opa[WIDTH-1]);
  assign b_mag     = cond_neg(opb, signed_op & opb[WIDTH-1]);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_FIX);
      if (accept) begin
        cnt <= CNT_W'(WIDTH - 1);
      end else if ((state == ST_CALC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Operand latch and iteration state
  always_ff @(posedge clock) begin
    if (accept) begin
      is_div   <= op_is_div;
      neg_q    <= signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
      neg_r    <= signed_op & op_is_div & opa[WIDTH-1];
      div0     <= op_is_div & (opb == '0);
      opa_orig <= opa;
      opb_mag  <= b_mag;
      acc_hi   <= '0;
      acc_lo   <= a_mag;
    end else if (state == ST_CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .hi     (acc_hi),
    .lo     (acc_lo),
    .b      (opb_mag),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Sign correction applied in FIX
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quo_fix  = cond_neg(acc_lo, neg_q);
    rem_fix  = cond_neg(acc_hi, neg_r);
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div && div0) begin
      fix_hi = opa_orig;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == ST_FIX) begin
      hi_out <= fix_hi;
      lo_out <= fix_lo;
    end else if ((state == ST_IDLE) && !start) begin
      if (mthi_en) hi_out <= wdata;
      if (mtlo_en) lo_out <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: latency, signed/unsigned results, mthi/mtlo, reset abort.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0, opb = '0;
  logic        mthi_en = 1'b0, mtlo_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .mthi_en (mthi_en),
    .mtlo_en (mtlo_en),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one op (start sampled at the next edge) and follows it to its done cycle.
  // inj > 0 drives a stray start plus mthi/mtlo during that busy cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inj);
    int busy_bad = 0;
    int done_bad = 0;
    int held_bad = 0;
    start = 1'b1; op = o; opa = a; opb = b;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c == inj) begin
        start = 1'b1; op = OP_DIVU; opa = 32'd1; opb = 32'd1;
        mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_bad++;
      if (hi_out !== cur_hi || lo_out !== cur_lo) held_bad++;
      tick();
      start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
    end
    check({tag, " busy_1to33"}, 64'(busy_bad), 64'd0);
    check({tag, " nodone_1to33"}, 64'(done_bad), 64'd0);
    check({tag, " hilo_held"}, 64'(held_bad), 64'd0);
    check({tag, " done_c34"}, 64'(done), 64'd1);
    check({tag, " idle_c34"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi_out), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_out), 64'(exp_lo));
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    int stray;
    tick();
    tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi_out), 64'd0);
    check("rst lo", 64'(lo_out), 64'd0);
    reset = 1'b0;

    mthi_en = 1'b1; wdata = 32'h0000_1234;
    tick();
    mthi_en = 1'b0;
    check("mthi hi", 64'(hi_out), 64'h1234);
    check("mthi lo", 64'(lo_out), 64'd0);
    mtlo_en = 1'b1; wdata = 32'h0000_5678;
    tick();
    mtlo_en = 1'b0;
    check("mtlo lo", 64'(lo_out), 64'h5678);
    check("mtlo hi", 64'(hi_out), 64'h1234);
    mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h0000_9ABC;
    tick();
    mthi_en = 1'b0; mtlo_en = 1'b0;
    check("mthilo hi", 64'(hi_out), 64'h9ABC);
    check("mthilo lo", 64'(lo_out), 64'h9ABC);
    cur_hi = 32'h9ABC; cur_lo = 32'h9ABC;

    // Consecutive run_op calls issue start on the previous done cycle.
    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div min/0", OP_DIV, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mult 3*4 inj", OP_MULT, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 5);
    tick();
    check("no stray op busy", 64'(busy), 64'd0);
    check("no stray op done", 64'(done), 64'd0);

    // Abort a divide at cycle 10.
    start = 1'b1; op = OP_DIV; opa = 32'd100; opb = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi_out), 64'd0);
    check("abort lo", 64'(lo_out), 64'd0);
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    check("abort quiet", 64'(stray), 64'd0);
    cur_hi = '0; cur_lo = '0;
    run_op("mult 6*7", OP_MULT, 32'd6, 32'd7, 32'h0000_0000, 32'd42, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
